// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding
// instruction-memory read at a time over a req/ack handshake, buffers the
// returned words in a small prefetch FIFO and presents {inst, inst_pc} to
// the core with valid/ready. Redirects flush the FIFO and retarget fetch.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [31:0]   drop_addr, drop_addr_next;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_after, count_next;
    logic          push, pop;
    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic          unused_rpc_lsbs;

    // Word alignment discards the low redirect bits.
    always_comb unused_rpc_lsbs = ^redirect_pc[1:0];

    // Handshake decode and FIFO occupancy; a redirect cancels push and pop.
    always_comb begin
        inst_valid  = (count != '0);
        pop         = inst_valid && inst_ready && !redirect;
        push        = (state == REQ) && imem_ack && !redirect;
        count_after = count + CW'(push) - CW'(pop);
        count_next  = redirect ? '0 : count_after;
        imem_req    = (state != IDLE);
        imem_addr   = (state == DROP) ? drop_addr : fetch_pc;
        inst        = inst_valid ? mem_inst[rd_ptr] : '0;
        inst_pc     = inst_valid ? mem_pc[rd_ptr]   : '0;
    end

    // Next-state logic: requests are only issued when the FIFO has room,
    // so a push can never land on a full FIFO.
    always_comb begin
        state_next     = state;
        fetch_pc_next  = fetch_pc;
        drop_addr_next = drop_addr;
        case (state)
            IDLE: begin
                if (count_after < CW'(DEPTH)) state_next = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    fetch_pc_next = fetch_pc + 32'd4;
                    state_next    = (count_after < CW'(DEPTH)) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_ack) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
        if (redirect) begin
            fetch_pc_next = {redirect_pc[31:2], 2'b00};
            case (state)
                REQ: begin
                    // A pending request is never withdrawn: remember its
                    // address and swallow its data when it finally returns.
                    if (imem_ack) begin
                        state_next = REQ;
                    end else begin
                        state_next     = DROP;
                        drop_addr_next = fetch_pc;
                    end
                end
                // If the dropped transfer completes in the redirect cycle
                // there is nothing left to discard, so fetch the new target.
                DROP:    state_next = imem_ack ? REQ : DROP;
                default: state_next = REQ;
            endcase
        end
    end

    // Control state, fetch PC and FIFO pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            drop_addr <= drop_addr_next;
            count     <= count_next;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // FIFO storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]   <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: cycle-exact vector table,
// directed redirect/reset sequences, and a randomized run checked against
// a stream-level model (consecutive PCs from the last redirect target).
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        imem_req2, imem_ack2, inst_valid2;
    logic [31:0] imem_addr2, imem_rdata2, inst2, inst_pc2;
    logic        inst_ready2 = 1'b1;
    logic        redirect2   = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;

    int errors = 0;
    int checks = 0;

    // Memory model: fixed or random ack latency, counted in request cycles.
    int unsigned lat_fixed = 0;
    bit          lat_rand  = 1'b0;
    int unsigned lat_cnt, cur_lat;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    always #5 clk = ~clk;

    assign imem_ack    = imem_req && (lat_cnt >= cur_lat);
    assign imem_rdata  = mem_word(imem_addr);
    assign imem_ack2   = imem_req2;
    assign imem_rdata2 = mem_word(imem_addr2);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= 0;
            cur_lat <= lat_fixed;
        end else if (imem_req && imem_ack) begin
            lat_cnt <= 0;
            cur_lat <= lat_rand ? $urandom_range(0, 3) : lat_fixed;
        end else if (imem_req) begin
            lat_cnt <= lat_cnt + 1;
        end
    end

    instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
        .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
        .inst_ready(inst_ready2),
        .redirect(redirect2), .redirect_pc(redirect_pc2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Leaves the bench at the negedge just before the first post-reset edge.
    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        ready;
        logic        valid;
        logic [31:0] pc;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[12];

    logic [31:0] exp_pc, prev_addr, rtgt;
    logic        prev_pending;
    int          pops;
    int          n;

    initial begin
        // Zero-wait memory: stream, then 5 stalled cycles saturating the FIFO.
        vecs[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
        vecs[2]  = '{1'b1, 1'b1, 32'h00, 1'b1, 32'h04};
        vecs[3]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h08};
        vecs[4]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0C};
        vecs[5]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0C};
        vecs[6]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0C};
        vecs[7]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0C};
        vecs[8]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0C};
        vecs[9]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h0C};
        vecs[10] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h10};
        vecs[11] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h14};

        lat_fixed = 0; lat_rand = 1'b0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            inst_ready = vecs[i].ready;
            #1;
            chk($sformatf("vec%0d valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].valid});
            chk($sformatf("vec%0d inst_pc", i), inst_pc, vecs[i].valid ? vecs[i].pc : 32'h0);
            chk($sformatf("vec%0d inst", i), inst, vecs[i].valid ? mem_word(vecs[i].pc) : 32'h0);
            chk($sformatf("vec%0d req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
            chk($sformatf("vec%0d addr", i), imem_addr, vecs[i].addr);
            @(negedge clk);
        end

        // RESET_PC near the top of the address space wraps modulo 2^32.
        do_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("wrap pc0", inst_pc2, 32'hFFFF_FFF8);
        chk("wrap inst0", inst2, mem_word(32'hFFFF_FFF8));
        @(negedge clk); #1;
        chk("wrap pc1", inst_pc2, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        chk("wrap pc2", inst_pc2, 32'h0000_0000);
        chk("wrap valid2", {31'b0, inst_valid2}, 32'h1);

        // Redirect while a 3-cycle read is pending: address held, data dropped.
        lat_fixed = 2;
        do_reset();
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_0100; inst_ready = 1'b1;
        #1;
        chk("drop req c1", {31'b0, imem_req}, 32'h1);
        chk("drop ack c1", {31'b0, imem_ack}, 32'h0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("drop addr held c2", imem_addr, 32'h0);
        chk("drop req held c2", {31'b0, imem_req}, 32'h1);
        @(negedge clk); #1;
        chk("drop addr held c3", imem_addr, 32'h0);
        chk("drop ack c3", {31'b0, imem_ack}, 32'h1);
        @(negedge clk); #1;
        chk("refetch addr", imem_addr, 32'h100);
        chk("drop valid", {31'b0, inst_valid}, 32'h0);
        n = 0;
        while (!inst_valid && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("after drop valid", {31'b0, inst_valid}, 32'h1);
        chk("after drop pc", inst_pc, 32'h100);
        chk("after drop inst", inst, mem_word(32'h100));

        // Redirect to an unaligned target in the same cycle as ack and pop.
        lat_fixed = 0;
        do_reset();
        repeat (2) @(negedge clk);
        inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0203;
        #1;
        chk("same-cycle pre valid", {31'b0, inst_valid}, 32'h1);
        chk("same-cycle pre ack", {31'b0, imem_ack}, 32'h1);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("flush valid N+1", {31'b0, inst_valid}, 32'h0);
        chk("flush inst_pc N+1", inst_pc, 32'h0);
        chk("retarget addr N+1", imem_addr, 32'h200);
        @(negedge clk); #1;
        chk("target valid N+2", {31'b0, inst_valid}, 32'h1);
        chk("target pc N+2", inst_pc, 32'h200);

        // Asynchronous reset with a request pending and the FIFO occupied.
        lat_fixed = 2;
        do_reset();
        repeat (4) @(negedge clk);
        #1;
        chk("pre-rst valid", {31'b0, inst_valid}, 32'h1);
        chk("pre-rst addr", imem_addr, 32'h4);
        #1;
        rst = 1'b1;
        #1;
        chk("async rst req", {31'b0, imem_req}, 32'h0);
        chk("async rst valid", {31'b0, inst_valid}, 32'h0);
        chk("async rst inst", inst, 32'h0);
        chk("async rst inst_pc", inst_pc, 32'h0);
        chk("async rst addr", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("refetch after rst req", {31'b0, imem_req}, 32'h1);
        chk("refetch after rst addr", imem_addr, 32'h0);

        // Randomized: accepted words must be consecutive PCs from the last target.
        lat_rand = 1'b1; lat_fixed = 1;
        do_reset();
        exp_pc = 32'h0; prev_pending = 1'b0; prev_addr = '0; pops = 0;
        for (int c = 0; c < 3000; c++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            redirect   = ($urandom_range(0, 19) == 0);
            rtgt       = $urandom;
            if ($urandom_range(0, 3) == 0) rtgt = 32'hFFFF_FFF0 | (rtgt & 32'hF);
            else rtgt = rtgt & 32'h0000_0FFF;
            redirect_pc = rtgt;
            #1;
            if (prev_pending) begin
                chk("rand req held", {31'b0, imem_req}, 32'h1);
                chk("rand addr held", imem_addr, prev_addr);
            end
            if (inst_valid) begin
                if (inst_ready && !redirect) begin
                    chk("rand inst_pc", inst_pc, exp_pc);
                    chk("rand inst", inst, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
            end else begin
                chk("rand empty head", inst | inst_pc, 32'h0);
            end
            if (redirect) exp_pc = {rtgt[31:2], 2'b00};
            prev_pending = imem_req && !imem_ack;
            prev_addr    = imem_addr;
            @(negedge clk);
        end
        redirect = 1'b0;
        chk("rand progress", (pops > 300) ? 32'h1 : 32'h0, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
